// File: rtl/apb_phase_fsm.sv
// APB requester phase sequencer: turns one AHB-side request into an APB SETUP/ACCESS
// transfer. Define APB_PHASE_FSM_TIMEOUT_EN to abort ACCESS after TMO_CYC wait states.
module apb_phase_fsm #(
  parameter  int NUM_SLV = 4,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TMO_CYC = 16,
  localparam int SLV_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic                      h_clk,
  input  logic                      h_resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [SLV_W-1:0]          req_slv,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic [NUM_SLV-1:0]        p_sel,
  output logic                      p_enable,
  output logic [ADDR_W-1:0]         p_addr,
  output logic                      p_write,
  output logic [DATA_W-1:0]         p_wdata,
  input  logic [NUM_SLV*DATA_W-1:0] p_rdata,
  input  logic [NUM_SLV-1:0]        p_ready,
  input  logic [NUM_SLV-1:0]        p_slverr,
  output logic [1:0]                dbg_state
);

  // Handshake: a request transfers on any cycle where req_valid && req_ready;
  // resp_valid is a single-cycle pulse carrying resp_err/resp_rdata, no back-pressure.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  localparam logic [SLV_W:0] NUM_SLV_L = (SLV_W+1)'(NUM_SLV);

  state_e              state_q, state_d;
  logic [SLV_W-1:0]    slv_q, slv_d;
  logic [NUM_SLV-1:0]  p_sel_q, p_sel_d;
  logic                p_enable_q, p_enable_d;
  logic [ADDR_W-1:0]   p_addr_q, p_addr_d;
  logic                p_write_q, p_write_d;
  logic [DATA_W-1:0]   p_wdata_q, p_wdata_d;
  logic                bad_slv_q, bad_slv_d;

  logic                sel_ready;
  logic                sel_slverr;
  logic [DATA_W-1:0]   sel_rdata;
  logic [NUM_SLV-1:0]  req_sel_oh;
  logic                in_range;
  logic                tmo_hit;
  logic                xfer_done;
  logic                accept;

  // Only the latched slave's response lines are ever looked at.
  always_comb begin
    sel_ready  = 1'b0;
    sel_slverr = 1'b0;
    sel_rdata  = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (slv_q == SLV_W'(k)) begin
        sel_ready  = p_ready[k];
        sel_slverr = p_slverr[k];
        sel_rdata  = p_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    req_sel_oh = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      req_sel_oh[k] = (req_slv == SLV_W'(k));
    end
  end

  assign in_range = ({1'b0, req_slv} < NUM_SLV_L);

`ifdef APB_PHASE_FSM_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == S_ACCESS) && !sel_ready && (tmo_cnt_q == 8'(TMO_CYC - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_SETUP) begin
      tmo_cnt_d = '0;
    end else if ((state_q == S_ACCESS) && !sel_ready && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge h_clk or negedge h_resetn) begin
    if (!h_resetn) tmo_cnt_q <= '0;
    else           tmo_cnt_q <= tmo_cnt_d;
  end
`else
  // TMO_CYC has no effect without the timeout build.
  assign tmo_hit = 1'b0 & (TMO_CYC > 0);
`endif

  assign xfer_done = (state_q == S_ACCESS) && (sel_ready || tmo_hit);
  assign req_ready = (state_q == S_IDLE) || xfer_done;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    slv_d      = slv_q;
    p_sel_d    = p_sel_q;
    p_enable_d = p_enable_q;
    p_addr_d   = p_addr_q;
    p_write_d  = p_write_q;
    p_wdata_d  = p_wdata_q;
    bad_slv_d  = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_SETUP: begin
        state_d    = S_ACCESS;
        p_enable_d = 1'b1;
      end
      S_ACCESS: begin
        if (xfer_done) begin
          state_d    = S_IDLE;
          p_sel_d    = '0;
          p_enable_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request taken on a completion cycle overrides the return to IDLE.
    if (accept) begin
      if (in_range) begin
        state_d    = S_SETUP;
        slv_d      = req_slv;
        p_sel_d    = req_sel_oh;
        p_enable_d = 1'b0;
        p_addr_d   = req_addr;
        p_write_d  = req_write;
        p_wdata_d  = req_wdata;
      end else begin
        state_d    = S_IDLE;
        p_sel_d    = '0;
        p_enable_d = 1'b0;
        bad_slv_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge h_clk or negedge h_resetn) begin
    if (!h_resetn) begin
      state_q    <= S_IDLE;
      slv_q      <= '0;
      p_sel_q    <= '0;
      p_enable_q <= 1'b0;
      p_addr_q   <= '0;
      p_write_q  <= 1'b0;
      p_wdata_q  <= '0;
      bad_slv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slv_q      <= slv_d;
      p_sel_q    <= p_sel_d;
      p_enable_q <= p_enable_d;
      p_addr_q   <= p_addr_d;
      p_write_q  <= p_write_d;
      p_wdata_q  <= p_wdata_d;
      bad_slv_q  <= bad_slv_d;
    end
  end

  // An out-of-range index answers from IDLE one cycle after acceptance.
  assign resp_valid = bad_slv_q || xfer_done;
  assign resp_err   = bad_slv_q || (xfer_done && (tmo_hit || sel_slverr));
  assign resp_rdata = (xfer_done && sel_ready && !p_write_q && !sel_slverr) ? sel_rdata : '0;

  assign p_sel     = p_sel_q;
  assign p_enable  = p_enable_q;
  assign p_addr    = p_addr_q;
  assign p_write   = p_write_q;
  assign p_wdata   = p_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_phase_fsm.sv
// Bench for apb_phase_fsm: vector table plus hand-written back-to-back, stall/timeout
// and reset-in-ACCESS sequences; responses are checked through an expected queue.
module tb_apb_phase_fsm;
  localparam int NUM_SLV = 5;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TMO_CYC = 4;
  localparam int SLV_W   = 3;

  logic                      h_clk;
  logic                      h_resetn;
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_W-1:0]         req_addr;
  logic [DATA_W-1:0]         req_wdata;
  logic [SLV_W-1:0]          req_slv;
  logic                      resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      resp_err;
  logic [NUM_SLV-1:0]        p_sel;
  logic                      p_enable;
  logic [ADDR_W-1:0]         p_addr;
  logic                      p_write;
  logic [DATA_W-1:0]         p_wdata;
  logic [NUM_SLV*DATA_W-1:0] p_rdata;
  logic [NUM_SLV-1:0]        p_ready;
  logic [NUM_SLV-1:0]        p_slverr;
  logic [1:0]                dbg_state;

  apb_phase_fsm #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
    .h_clk(h_clk), .h_resetn(h_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_slv(req_slv),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .p_sel(p_sel), .p_enable(p_enable), .p_addr(p_addr), .p_write(p_write),
    .p_wdata(p_wdata), .p_rdata(p_rdata), .p_ready(p_ready), .p_slverr(p_slverr),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [SLV_W-1:0]  slv;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                waits;
    logic              slverr;
    logic              exp_err;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  logic [DATA_W:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  initial h_clk = 1'b0;
  always #5 h_clk = ~h_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Selected slave gets the given response; every other slave sees noise.
  task automatic drive_slaves(input int sel, input logic rdy, input logic err, input logic [DATA_W-1:0] rd);
    for (int k = 0; k < NUM_SLV; k++) begin
      if (k == sel) begin
        p_ready[k]                = rdy;
        p_slverr[k]               = err;
        p_rdata[k*DATA_W +: DATA_W] = rd;
      end else begin
        p_ready[k]                = 1'($urandom);
        p_slverr[k]               = 1'($urandom);
        p_rdata[k*DATA_W +: DATA_W] = $urandom;
      end
    end
  endtask

  function automatic vec_t mk(input int slv, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int waits, input logic slverr);
    vec_t v;
    v.slv = SLV_W'(slv); v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.waits = waits; v.slverr = slverr;
    if (slv >= NUM_SLV) begin
      v.exp_err = 1'b1; v.exp_rdata = '0;
    end else begin
      v.exp_err   = slverr;
      v.exp_rdata = (!wr && !slverr) ? rdata : '0;
    end
    return v;
  endfunction

  // driver: one complete transfer, checking APB phases cycle by cycle
  task automatic do_xfer(input vec_t v);
    logic [NUM_SLV-1:0] oh;
    logic in_rng;
    in_rng = (int'(v.slv) < NUM_SLV);
    oh = '0;
    if (in_rng) oh[v.slv] = 1'b1;
    @(negedge h_clk);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_slv = v.slv;
    drive_slaves(int'(v.slv), 1'($urandom), 1'($urandom), $urandom);
    #1 check("accept_ready", req_ready, 1);
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(negedge h_clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);
    drive_slaves(int'(v.slv), 1'($urandom), 1'($urandom), $urandom);
    #1;
    if (!in_rng) begin
      check("oor_psel", p_sel, 0);
      check("oor_penable", p_enable, 0);
      check("oor_resp_valid", resp_valid, 1);
    end else begin
      check("setup_psel", p_sel, oh);
      check("setup_penable", p_enable, 0);
      check("setup_addr", p_addr, v.addr);
      check("setup_write", p_write, v.wr);
      if (v.wr) check("setup_wdata", p_wdata, v.wdata);
      check("setup_resp_valid", resp_valid, 0);
      for (int w = 0; w <= v.waits; w++) begin
        @(negedge h_clk);
        drive_slaves(int'(v.slv), (w == v.waits), v.slverr, v.rdata);
        #1;
        check("access_penable", p_enable, 1);
        check("access_psel", p_sel, oh);
        check("access_addr", p_addr, v.addr);
        check("access_resp_valid", resp_valid, (w == v.waits));
        check("access_req_ready", req_ready, (w == v.waits));
      end
    end
    @(negedge h_clk);
    drive_slaves(int'(v.slv), 1'($urandom), 1'($urandom), $urandom);
    #1;
    check("idle_psel", p_sel, 0);
    check("idle_penable", p_enable, 0);
    check("idle_resp_valid", resp_valid, 0);
  endtask

  // scoreboard: every response pulse must match the head of the expected queue
  always @(negedge h_clk) begin
    #2;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got resp_valid=1 required no response");
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        check("sb_resp_err", resp_err, e[DATA_W]);
        check("sb_resp_rdata", resp_rdata, e[DATA_W-1:0]);
      end
    end
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = mk(2, 1'b1, 32'h40,  32'hA5A5A5A5, 32'h0,        0, 1'b0);
    vecs[1] = mk(1, 1'b0, 32'h104, 32'h0,        32'h12345678, 3, 1'b0);
    vecs[2] = mk(0, 1'b0, 32'h8,   32'h0,        32'hDEADBEEF, 0, 1'b1);
    vecs[3] = mk(4, 1'b0, 32'hFFC, 32'h0,        32'hCAFEF00D, 1, 1'b0);
    vecs[4] = mk(3, 1'b1, 32'h30,  32'h5A5A0F0F, 32'h11111111, 2, 1'b1);
    vecs[5] = mk(5, 1'b1, 32'h50,  32'h12121212, 32'h0,        0, 1'b0);
    vecs[6] = mk(7, 1'b0, 32'h70,  32'h0,        32'h33333333, 0, 1'b0);
    vecs[7] = mk(4, 1'b0, 32'h44,  32'h0,        32'h0F0F0F0F, 0, 1'b0);

    h_resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_slv = '0;
    p_rdata = '0; p_ready = '0; p_slverr = '0;
    repeat (3) @(negedge h_clk);
    drive_slaves(0, 1'b1, 1'b1, 32'hFFFFFFFF);
    #1;
    check("rst_psel", p_sel, 0);
    check("rst_penable", p_enable, 0);
    check("rst_paddr", p_addr, 0);
    check("rst_pwdata", p_wdata, 0);
    check("rst_pwrite", p_write, 0);
    check("rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
    @(negedge h_clk);
    h_resetn = 1'b1;
    #1 check("rst_release_ready", req_ready, 1);

    for (int i = 0; i < 8; i++) do_xfer(vecs[i]);

    for (int i = 0; i < 8; i++) begin
      do_xfer(mk($urandom_range(0, 6), 1'($urandom), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), 1'($urandom)));
    end

    // back-to-back: request B is taken on A's completion cycle
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'h0BADCAFE});
    @(negedge h_clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_wdata = 32'h11112222; req_slv = 3'd1;
    #1 check("b2b_accept_a", req_ready, 1);
    @(negedge h_clk);
    req_write = 1'b0; req_addr = 32'h300; req_wdata = 32'h0; req_slv = 3'd3;
    drive_slaves(1, 1'b1, 1'b0, 32'h0);
    #1;
    check("b2b_setup_a_psel", p_sel, 5'b00010);
    check("b2b_setup_a_ready", req_ready, 0);
    @(negedge h_clk);
    drive_slaves(1, 1'b1, 1'b0, 32'h0);
    #1;
    check("b2b_access_a_resp", resp_valid, 1);
    check("b2b_access_a_ready", req_ready, 1);
    @(negedge h_clk);
    req_valid = 1'b0;
    drive_slaves(3, 1'b1, 1'b1, 32'h0);
    #1;
    check("b2b_setup_b_psel", p_sel, 5'b01000);
    check("b2b_setup_b_penable", p_enable, 0);
    check("b2b_setup_b_addr", p_addr, 32'h300);
    check("b2b_setup_b_write", p_write, 0);
    @(negedge h_clk);
    drive_slaves(3, 1'b1, 1'b0, 32'h0BADCAFE);
    #1 check("b2b_access_b_resp", resp_valid, 1);
    @(negedge h_clk);
    drive_slaves(3, 1'b0, 1'b0, 32'h0);
    #1 check("b2b_idle_psel", p_sel, 0);

    // selected p_ready stuck low
`ifdef APB_PHASE_FSM_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'h0});
`else
    exp_q.push_back({1'b0, 32'h77777777});
`endif
    @(negedge h_clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h500; req_slv = 3'd2;
    #1 check("stall_accept", req_ready, 1);
    @(negedge h_clk);
    req_valid = 1'b0;
    drive_slaves(2, 1'b0, 1'b0, 32'h0);
`ifdef APB_PHASE_FSM_TIMEOUT_EN
    for (int w = 0; w < TMO_CYC; w++) begin
      @(negedge h_clk);
      drive_slaves(2, 1'b0, 1'b0, 32'h99999999);
      #1;
      check("tmo_penable", p_enable, 1);
      check("tmo_resp_valid", resp_valid, (w == TMO_CYC - 1));
      check("tmo_req_ready", req_ready, (w == TMO_CYC - 1));
    end
    @(negedge h_clk);
    drive_slaves(2, 1'b0, 1'b0, 32'h0);
    #1;
    check("tmo_drop_psel", p_sel, 0);
    check("tmo_drop_penable", p_enable, 0);
`else
    for (int w = 0; w < 20; w++) begin
      @(negedge h_clk);
      drive_slaves(2, 1'b0, 1'b0, 32'h99999999);
      #1;
      check("stall_penable", p_enable, 1);
      check("stall_resp_valid", resp_valid, 0);
    end
    @(negedge h_clk);
    drive_slaves(2, 1'b1, 1'b0, 32'h77777777);
    #1 check("stall_release_resp", resp_valid, 1);
    @(negedge h_clk);
    drive_slaves(2, 1'b0, 1'b0, 32'h0);
    #1 check("stall_idle_psel", p_sel, 0);
`endif

    // reset asserted during ACCESS: transfer vanishes without a response
    @(negedge h_clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h600; req_wdata = 32'hABCDEF01; req_slv = 3'd4;
    #1 check("rst_mid_accept", req_ready, 1);
    @(negedge h_clk);
    req_valid = 1'b0;
    drive_slaves(4, 1'b0, 1'b0, 32'h0);
    @(negedge h_clk);
    drive_slaves(4, 1'b0, 1'b0, 32'h0);
    #1 check("rst_mid_in_access", p_enable, 1);
    h_resetn = 1'b0;
    #1;
    check("rst_mid_psel", p_sel, 0);
    check("rst_mid_penable", p_enable, 0);
    check("rst_mid_paddr", p_addr, 0);
    check("rst_mid_pwdata", p_wdata, 0);
    check("rst_mid_resp", {resp_valid, resp_err, resp_rdata}, 0);
    check("rst_mid_ready", req_ready, 1);
    @(negedge h_clk);
    drive_slaves(4, 1'b1, 1'b0, 32'h0);
    #1 check("rst_mid_no_resp", resp_valid, 0);
    @(negedge h_clk);
    h_resetn = 1'b1;
    #1;
    check("rst_mid_release_ready", req_ready, 1);
    check("rst_mid_release_psel", p_sel, 0);

    do_xfer(mk(0, 1'b0, 32'hA0, 32'h0, 32'h55AA55AA, 1, 1'b0));

    repeat (2) @(negedge h_clk);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
